// File: rtl/bitcount_unit_if.sv
// bitcount_unit_if: request/response bundle between the execute stage and the
// bit-counting coprocessor.
//   start - request pulse (requester -> unit)
//   mode  - operation select, sampled with start
//   A     - WIDTH-bit operand, sampled with start
//   clr   - synchronous abort (pipeline flush)
//   busy  - operation in progress (unit -> requester)
//   done  - one-cycle completion pulse
//   cnt   - 32-bit zero-extended result, held until the next done
// Modports: master = requester side, slave = coprocessor side.
`timescale 1ns/1ps
interface bitcount_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic             clr;
  logic             busy;
  logic             done;
  logic [31:0]      cnt;

  modport master (
    output start, mode, A, clr,
    input  busy, done, cnt
  );

  modport slave (
    input  start, mode, A, clr,
    output busy, done, cnt
  );
endinterface

// File: rtl/bitcount_unit.sv
// bitcount_unit: multi-cycle popcount / clz / clo / ctz coprocessor.
// Examines STEP bits per cycle, fixed latency N = WIDTH/STEP cycles.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears all state
//   bus   - bitcount_unit_if.slave: start/mode/A/clr in, busy/done/cnt out
// WIDTH must be a multiple of STEP.
`timescale 1ns/1ps
module bitcount_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  bitcount_unit_if.slave  bus
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = $clog2(WIDTH + 1);
  localparam int unsigned CW = $clog2(STEP + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_shift;
  logic [AW-1:0]    r_acc;
  logic             r_found;
  logic             r_pop;
  logic             r_done;
  logic [31:0]      r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_operand;
  logic [STEP-1:0]  w_chunk;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_lz;
  logic [AW-1:0]    w_acc_next;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.clr;
  assign w_last   = (r_k == KW'(N - 1));
  assign w_chunk  = r_shift[WIDTH-1 -: STEP];

  // Every mode is folded into popcount or a leading-zero scan from the MSB:
  // clo scans ~A, ctz scans A with its bits reversed.
  always_comb begin
    w_operand = bus.A;
    case (bus.mode)
      2'b00, 2'b01: w_operand = bus.A;
      2'b10:        w_operand = ~bus.A;
      2'b11: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          w_operand[i] = bus.A[int'(WIDTH) - 1 - i];
        end
      end
      default:      w_operand = bus.A;
    endcase
  end

  // Per-chunk ones count and leading-zero count. The lz loop walks upward so
  // the highest set bit is the last to write, leaving its distance from the MSB.
  always_comb begin
    w_pop = '0;
    w_lz  = CW'(STEP);
    for (int i = 0; i < int'(STEP); i++) begin
      w_pop = w_pop + CW'(w_chunk[i]);
      if (w_chunk[i]) begin
        w_lz = CW'(int'(STEP) - 1 - i);
      end
    end
  end

  // Once a scan has hit a one, later chunks no longer contribute.
  always_comb begin
    w_acc_next = r_acc;
    if (r_pop) begin
      w_acc_next = r_acc + AW'(w_pop);
    end else if (!r_found) begin
      w_acc_next = r_acc + AW'(w_lz);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_found <= 1'b0;
      r_pop   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_k     <= '0;
            r_shift <= w_operand;
            r_acc   <= '0;
            r_found <= 1'b0;
            r_pop   <= (bus.mode == 2'b00);
          end
        end
        S_RUN: begin
          if (bus.clr) begin
            // Flush: drop the operation silently, cnt keeps its old value.
            r_state <= S_IDLE;
            r_k     <= '0;
          end else begin
            r_shift <= r_shift << STEP;
            r_acc   <= w_acc_next;
            r_found <= r_found | (w_chunk != '0);
            r_k     <= r_k + KW'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_k     <= '0;
              r_done  <= 1'b1;
              r_cnt   <= 32'(w_acc_next);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.cnt  = r_cnt;

endmodule

// File: tb/tb_bitcount_unit.sv
`timescale 1ns/1ps
module tb_bitcount_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bitcount_unit_if #(.WIDTH(32)) bus32 ();
  bitcount_unit_if #(.WIDTH(8))  bus8 ();
  bitcount_unit_if #(.WIDTH(16)) bus16 ();

  bitcount_unit #(.WIDTH(32), .STEP(4)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  bitcount_unit #(.WIDTH(8),  .STEP(8)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
  bitcount_unit #(.WIDTH(16), .STEP(2)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses start over one posedge, returns at the next negedge.
  task automatic issue(input logic [1:0] m, input logic [31:0] a);
    bus32.start = 1'b1;
    bus32.mode  = m;
    bus32.A     = a;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("accept_busy", 32'(bus32.busy), 32'd1);
  endtask

  // Counts negedges until done; returns at the negedge where done is high.
  task automatic wait_done(input int exp_lat, input logic [31:0] exp_cnt, input string tag);
    int cyc = 0;
    int bad = 0;
    while (bus32.done !== 1'b1 && cyc < 100) begin
      if (bus32.busy !== 1'b1) bad++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_cnt"}, bus32.cnt, exp_cnt);
    chk({tag, "_busy_at_done"}, 32'(bus32.busy), 32'd0);
    chk({tag, "_busy_gaps"}, 32'(bad), 32'd0);
  endtask

  task automatic watch_idle(input int cycles, input string tag);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    bus32.start = 1'b0; bus32.mode = 2'b00; bus32.A = '0; bus32.clr = 1'b0;
    bus8.start  = 1'b0; bus8.mode  = 2'b00; bus8.A  = '0; bus8.clr  = 1'b0;
    bus16.start = 1'b0; bus16.mode = 2'b00; bus16.A = '0; bus16.clr = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus32.busy), 32'd0);
    chk("rst_done", 32'(bus32.done), 32'd0);
    chk("rst_cnt", bus32.cnt, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic operations, each from idle
    issue(2'b00, 32'hF0F0_0001);
    wait_done(8, 32'd9, "pop");
    @(negedge clk);
    chk("done_one_cycle", 32'(bus32.done), 32'd0);
    issue(2'b01, 32'h0000_8000); wait_done(8, 32'd16, "clz_8000"); @(negedge clk);
    issue(2'b01, 32'h0000_0000); wait_done(8, 32'd32, "clz_0");    @(negedge clk);
    issue(2'b10, 32'hFFFF_FFFE); wait_done(8, 32'd31, "clo");      @(negedge clk);
    issue(2'b11, 32'h0000_0100); wait_done(8, 32'd8,  "ctz_100");  @(negedge clk);
    issue(2'b11, 32'h0000_0000); wait_done(8, 32'd32, "ctz_0");    @(negedge clk);

    // start while busy is ignored
    issue(2'b00, 32'hF0F0_0001);
    bus32.start = 1'b1; bus32.mode = 2'b01; bus32.A = 32'h0;
    @(negedge clk);
    bus32.start = 1'b0;
    wait_done(7, 32'd9, "ignore_start");

    // Back-to-back: start in the done cycle
    chk("b2b_done_now", 32'(bus32.done), 32'd1);
    issue(2'b11, 32'h0000_0100);
    wait_done(8, 32'd8, "b2b");
    @(negedge clk);

    // Abort at k=3 with cnt=9 as precondition
    issue(2'b00, 32'hF0F0_0001); wait_done(8, 32'd9, "pre_abort"); @(negedge clk);
    issue(2'b01, 32'h0000_8000);
    repeat (3) @(negedge clk);
    bus32.clr = 1'b1;
    @(negedge clk);
    bus32.clr = 1'b0;
    chk("abort_busy", 32'(bus32.busy), 32'd0);
    chk("abort_done", 32'(bus32.done), 32'd0);
    chk("abort_cnt", bus32.cnt, 32'd9);
    watch_idle(12, "abort_quiet");

    // clr and start together in idle: not accepted
    bus32.clr = 1'b1; bus32.start = 1'b1; bus32.mode = 2'b00; bus32.A = 32'hFFFF_FFFF;
    @(negedge clk);
    bus32.clr = 1'b0; bus32.start = 1'b0;
    chk("clr_start_busy", 32'(bus32.busy), 32'd0);
    watch_idle(12, "clr_start_quiet");
    chk("clr_start_cnt", bus32.cnt, 32'd9);

    // Asynchronous reset mid-run, between clock edges
    issue(2'b00, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus32.busy), 32'd0);
    chk("async_rst_done", 32'(bus32.done), 32'd0);
    chk("async_rst_cnt", bus32.cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_idle(12, "post_rst_quiet");
    issue(2'b11, 32'h0000_0100);
    wait_done(8, 32'd8, "post_rst");
    @(negedge clk);

    // WIDTH=8, STEP=8: single-cycle latency
    bus8.start = 1'b1; bus8.mode = 2'b00; bus8.A = 8'hA5;
    @(negedge clk);
    bus8.start = 1'b0;
    chk("w8_busy", 32'(bus8.busy), 32'd1);
    chk("w8_no_early_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    chk("w8_done", 32'(bus8.done), 32'd1);
    chk("w8_cnt", bus8.cnt, 32'd4);
    chk("w8_busy_low", 32'(bus8.busy), 32'd0);

    // WIDTH=16, STEP=2: clz(0x0001)=15 in 8 cycles
    bus16.start = 1'b1; bus16.mode = 2'b01; bus16.A = 16'h0001;
    @(negedge clk);
    bus16.start = 1'b0;
    cyc = 0;
    while (bus16.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16_lat", 32'(cyc), 32'd8);
    chk("w16_cnt", bus16.cnt, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitcount_unit.md
Name: bitcount_unit

Overview:
- Multi-cycle bit-counting coprocessor beside the ALU/MDU in the execute stage; generalised successor of the single-cycle count path.
- Computes population count, count-leading-zeros, count-leading-ones or count-trailing-zeros of a WIDTH-bit operand.
- Consumes STEP bits per cycle with a start/busy/done handshake, and supports abort for exception flush.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of STEP.
- STEP, 4, bits examined per cycle; latency N = WIDTH/STEP cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request. Accepted only when busy=0 and clr=0.
- mode  input  2  operation, sampled with start: 00 popcount, 01 clz, 10 clo, 11 ctz.
- A  input  WIDTH  operand, sampled with start.
- clr  input  1  synchronous abort (pipeline flush on exception).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; cnt valid and updated.
- cnt  output  32  result, zero-extended; held until the next done.

Behaviour:
- Reset (async): busy=0, done=0, cnt=0, step counter=0, internal shift register=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, step counter k counts 0..N-1.
  - Return to IDLE after the last step.
- Accept (IDLE, start=1, clr=0) at edge t0:
  - Latch the operand transformed so that every mode reduces to popcount or leading-zero scan from the MSB: mode 00 and 01 use A; mode 10 uses ~A; mode 11 uses bit-reversed A.
  - Clear the accumulator and found flag; enter RUN; k=0.
- Each RUN cycle, take the top STEP bits of the shift register, then shift left by STEP:
  - popcount mode: accumulator += number of ones in the chunk.
  - scan modes (01/10/11), found=0: accumulator += leading zeros of the chunk. If the chunk is nonzero, set found=1.
  - scan modes, found=1: accumulator unchanged.
- Latency is fixed at N cycles regardless of data; there is no early termination.
- At edge t0+N:
  - cnt <= final accumulator.
  - done=1 for exactly that cycle.
  - busy=0.
- Accumulator is clog2(WIDTH+1) bits wide, and the result range is 0..WIDTH. All-zero operand in scan modes gives WIDTH, e.g. clz(0)=32 and clo(0xFFFFFFFF)=32.
- start while busy=1 is ignored: no effect on the operand or the result.
- Back-to-back: start is accepted in the cycle done=1 because busy=0 then. The next done follows N cycles later.
- clr during RUN:
  - Next edge returns to IDLE, busy=0.
  - No done pulse; cnt keeps its previous value.
- clr and start in the same cycle: clr wins and start is dropped.
- clr in IDLE: no effect.
- Reset asserted mid-operation: outputs go to reset values immediately. The operation is lost, and there is no done after reset is released.
- done and busy are never both 1.
- STEP=WIDTH is legal: N=1.

Test Plan:
- Popcount, WIDTH=32, STEP=4: start with mode=00, A=0xF0F00001 -> busy=1 for 8 cycles, done pulses 8 cycles after the accept edge, cnt=9.
- Scan modes, one per operation:
  - mode=01, A=0x00008000 -> cnt=16.
  - mode=01, A=0 -> cnt=32.
  - mode=10, A=0xFFFFFFFE -> cnt=31.
  - mode=11, A=0x00000100 -> cnt=8.
  - mode=11, A=0 -> cnt=32.
  - Each completes in exactly 8 cycles.
- Handshake:
  - start again while busy with different A -> ignored; result matches the first operand.
  - start asserted in the done cycle -> second result 8 cycles later, no idle gap.
- Abort:
  - Precondition: cnt=9 from an earlier operation.
  - New operation, clr at k=3 -> busy=0 next cycle, no done, cnt stays 9.
  - clr+start together in IDLE -> not accepted.
- Reset:
  - Assert reset asynchronously mid-RUN, between clock edges -> busy/done/cnt=0 without waiting for a clock edge.
  - After release -> no spurious done; a new start completes normally.
- Parameter sweep:
  - WIDTH=8, STEP=8: mode=00, A=0xA5 -> cnt=4 with done one cycle after accept.
  - WIDTH=16, STEP=2: mode=01, A=0x0001 -> cnt=15 after 8 cycles.
